// File: rtl/msx_joyport_pkg.sv
// Shared types and constants for the MSX joystick port A arbiter.
// Covers source state, force-mode codes and idle pin levels.
package msx_joyport_pkg;

  typedef enum logic [1:0] {
    JOY      = 2'd0,
    TO_MOUSE = 2'd1,
    MOUSE    = 2'd2,
    TO_JOY   = 2'd3
  } state_t;

  localparam logic [1:0] FM_AUTO  = 2'b00;
  localparam logic [1:0] FM_JOY   = 2'b01;
  localparam logic [1:0] FM_MOUSE = 2'b10;

  localparam logic [5:0] PJOY_IDLE = 6'h3F;

  // MiSTer active-high joystick to MSX active-low pin order
  function automatic logic [5:0] joy_to_pjoy(
    input logic [5:0] j
  );
    return ~{j[5], j[4], j[0], j[1], j[2], j[3]};
  endfunction

endpackage

// File: rtl/msx_joyport_if.sv
// Joystick port A bus between the input sources and the MSX pins.
// master drives the sources, slave is the arbiter.
interface msx_joyport_if;
  logic [5:0] joy;
  logic [5:0] mouse_data;
  logic       mouse_act;
  logic       port_str;
  logic [5:0] pjoy;
  logic       mouse_str;

  modport master (
    output joy, mouse_data, mouse_act, port_str,
    input  pjoy, mouse_str
  );

  modport slave (
    input  joy, mouse_data, mouse_act, port_str,
    output pjoy, mouse_str
  );
endinterface

// File: rtl/msx_joyport_timer.sv
// Loadable down-counter that stops at zero.
// Shared by the switch guard and the mouse idle timeout.
module msx_joyport_timer #(
  parameter int CNT_W = 25
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/msx_joyport_arbiter.sv
// Shares MSX joystick port A between the MiSTer joystick and the
// PS/2 mouse, with an all-released guard on every source change.
module msx_joyport_arbiter
  import msx_joyport_pkg::*;
#(
  parameter int GUARD_CYCLES = 21477,
  parameter int IDLE_CYCLES  = 21477270,
  parameter int CNT_W        = 25
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  msx_joyport_if.slave  jp,
  input  logic [1:0]    force_mode,
  output logic          mode,
  output logic          switch_evt
);

  localparam logic [CNT_W-1:0] GUARD_LD =
    CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LD =
    CNT_W'(IDLE_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  logic             str_q;
  logic             str_edge;
  logic             joy_any;
  logic             reload;
  logic             fm_joy;
  logic             fm_mouse;
  logic             fm_auto;
  logic             ld;
  logic [CNT_W-1:0] ld_val;
  logic             cnt_zero;
  logic             evt_nx;
  logic [5:0]       pjoy_nx;
  logic             str_nx;

  assign joy_any  = |jp.joy;
  assign str_edge = jp.port_str ^ str_q;
  assign reload   = jp.mouse_act | str_edge;
  assign fm_joy   = (force_mode == FM_JOY);
  assign fm_mouse = (force_mode == FM_MOUSE);
  assign fm_auto  = !fm_joy && !fm_mouse;

  msx_joyport_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .load    (ld),
    .value   (ld_val),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    ld_val   = GUARD_LD;
    unique case (state)
      JOY: begin
        if (fm_mouse ||
            (fm_auto && jp.mouse_act && !joy_any)) begin
          state_nx = TO_MOUSE;
          ld       = 1'b1;
        end
      end
      TO_MOUSE: begin
        if (fm_joy || (fm_auto && joy_any)) begin
          state_nx = JOY;
        end else if (cnt_zero) begin
          state_nx = MOUSE;
          ld       = 1'b1;
          ld_val   = IDLE_LD;
        end
      end
      MOUSE: begin
        // forced mouse suppresses both joystick and idle exits
        if (fm_joy ||
            (fm_auto &&
             (joy_any || (cnt_zero && !reload)))) begin
          state_nx = TO_JOY;
          ld       = 1'b1;
        end else if (reload) begin
          ld       = 1'b1;
          ld_val   = IDLE_LD;
        end
      end
      TO_JOY: begin
        if (fm_mouse) begin
          state_nx = MOUSE;
          ld       = 1'b1;
          ld_val   = IDLE_LD;
        end else if (cnt_zero) begin
          state_nx = JOY;
        end
      end
      default: state_nx = JOY;
    endcase
  end

  always_comb begin
    evt_nx  = ((state == TO_MOUSE) && (state_nx == MOUSE)) ||
              ((state == TO_JOY) && (state_nx == JOY));
    pjoy_nx = PJOY_IDLE;
    str_nx  = 1'b0;
    unique case (state_nx)
      JOY:     pjoy_nx = joy_to_pjoy(jp.joy);
      MOUSE: begin
        pjoy_nx = jp.mouse_data;
        str_nx  = jp.port_str;
      end
      default: pjoy_nx = PJOY_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state        <= JOY;
      str_q        <= 1'b0;
      jp.pjoy      <= PJOY_IDLE;
      jp.mouse_str <= 1'b0;
      mode         <= 1'b0;
      switch_evt   <= 1'b0;
    end else begin
      state        <= state_nx;
      str_q        <= jp.port_str;
      jp.pjoy      <= pjoy_nx;
      jp.mouse_str <= str_nx;
      mode         <= (state_nx == TO_MOUSE) ||
                      (state_nx == MOUSE);
      switch_evt   <= evt_nx;
    end
  end

endmodule
